// File: rtl/irq_reset_ctrl.sv
// CPU reset sequencer plus N-source 68000 interrupt priority encoder.
// Sources are synchronised, optionally edge-latched, masked and encoded onto _IPL.
module irq_reset_ctrl #(
    parameter int unsigned               NUM_SRC      = 4,
    parameter logic [3*NUM_SRC-1:0]      SRC_LEVEL    = {3'd1, 3'd4, 3'd5, 3'd6},
    parameter logic [NUM_SRC-1:0]        EDGE_MODE    = '0,
    parameter int unsigned               RESET_CYCLES = 800000,
    parameter int unsigned               CNT_W        = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cep,
    input  logic               soft_reset,
    output logic               cpu_reset_n,
    input  logic [NUM_SRC-1:0] irq_n,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] pending,
    input  logic               iack,
    input  logic [2:0]         iack_level,
    output logic [2:0]         ipl_n
);

    localparam int unsigned LVL_W = 3;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_cpu_reset_n;
    logic [NUM_SRC-1:0] r_s1;
    logic [NUM_SRC-1:0] r_s2;
    logic [NUM_SRC-1:0] r_s3;
    logic [NUM_SRC-1:0] r_latch;
    logic [NUM_SRC-1:0] r_mask;
    logic [LVL_W-1:0]   r_ipl_n;

    logic               w_hold;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic               w_clr_found;
    logic [NUM_SRC-1:0] w_pending;
    logic [LVL_W-1:0]   w_max_lvl;

    // Interrupt state is held inert during any reset request or while the CPU is in reset.
    assign w_hold = reset | soft_reset | ~r_cpu_reset_n;

    // Reset counter: reload on reset/soft_reset, count down on cep ticks.
    always_ff @(posedge clk) begin
        if (reset || soft_reset) begin
            r_cnt         <= CNT_W'(RESET_CYCLES);
            r_cpu_reset_n <= 1'b0;
        end else begin
            if (cep && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_cpu_reset_n <= (r_cnt == '0);
        end
    end

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '1;
            r_s2 <= '1;
            r_s3 <= '1;
        end else begin
            r_s1 <= irq_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_set = EDGE_MODE & r_s3 & ~r_s2;

    // Acknowledge clears only the lowest-index set edge latch at the acknowledged level.
    always_comb begin
        w_clr       = '0;
        w_clr_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (iack && EDGE_MODE[i] && r_latch[i] && !w_clr_found &&
                (iack_level == SRC_LEVEL[LVL_W*i +: LVL_W])) begin
                w_clr[i]    = 1'b1;
                w_clr_found = 1'b1;
            end
        end
    end

    // Edge latches: a new edge in the same cycle as its clear keeps the latch set.
    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_latch <= '0;
        end else begin
            r_latch <= (r_latch & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_mask <= '1;
        end else if (mask_we) begin
            r_mask <= mask_wdata;
        end
    end

    assign w_pending = (EDGE_MODE & r_latch) | (~EDGE_MODE & ~r_s2);

    // Highest enabled level wins; level 0 never exceeds the zero default, so disabled sources drop out.
    always_comb begin
        w_max_lvl = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (w_pending[i] && r_mask[i] &&
                (SRC_LEVEL[LVL_W*i +: LVL_W] > w_max_lvl)) begin
                w_max_lvl = SRC_LEVEL[LVL_W*i +: LVL_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_ipl_n <= '1;
        end else begin
            r_ipl_n <= ~w_max_lvl;
        end
    end

    assign cpu_reset_n = r_cpu_reset_n;
    assign mask        = r_mask;
    assign pending     = w_pending;
    assign ipl_n       = r_ipl_n;

endmodule
